// File: rtl/mult_cell_arbiter.sv
// Round-robin front end for a shared pipelined 16x16 partial-product multiply cell.
// Grants one 32x32 request at a time, runs the cell for MUL_LATENCY enabled cycles,
// folds the partial products into a 32-bit result, and returns it tagged with the
// index of the requester that owns it.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | searching for a request from the rr pointer upward
// ISSUE   | mul_en high; operands held while the cell pipeline fills
// COMBINE | cell frozen; partial products summed into rsp_data
// RESP    | rsp_valid high until the consumer takes the result
module mult_cell_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ID_W        = $clog2(NUM_REQ),
  parameter int MUL_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_src1,
  input  logic [NUM_REQ*32-1:0]   req_src2,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic [31:0]             mul_src1,
  output logic [31:0]             mul_src2,
  output logic                    mul_en,
  input  logic [31:0]             mul_p1,
  input  logic [31:0]             mul_p2,
  input  logic [31:0]             mul_p3,
  output logic                    busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_COMBINE, ST_RESP} state_t;

  // Loaded with MUL_LATENCY-1 so the terminal count lands on the last enabled cycle.
  localparam logic [1:0] LAT_LOAD = 2'(MUL_LATENCY - 1);

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   rr_nxt;
  logic [1:0]        lat_cnt;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic              found_hi, found_lo;
  logic [ID_W-1:0]   idx_hi, idx_lo;
  logic [31:0]       sel_src1, sel_src2;

  // Round-robin pick: first valid at or above rr_ptr, otherwise first valid below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_hi && req_valid[i] && (i >= int'(rr_ptr))) begin
        found_hi = 1'b1;
        idx_hi   = ID_W'(i);
      end
      if (!found_lo && req_valid[i] && (i < int'(rr_ptr))) begin
        found_lo = 1'b1;
        idx_lo   = ID_W'(i);
      end
    end
    grant_vld = found_hi || found_lo;
    grant_idx = found_hi ? idx_hi : idx_lo;
    rr_nxt    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_src1 = '0;
    sel_src2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_idx) begin
        sel_src1 = req_src1[32*i +: 32];
        sel_src2 = req_src2[32*i +: 32];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and control outputs; a grant in IDLE is always a handshake.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    mul_en    = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (grant_vld) begin
          req_ready[grant_idx] = 1'b1;
          state_nxt            = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mul_en = 1'b1;
        if (lat_cnt == 2'd0) state_nxt = ST_COMBINE;
      end
      ST_COMBINE: state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, issue timer, result combine and rr pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      lat_cnt  <= '0;
      mul_src1 <= '0;
      mul_src2 <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            mul_src1 <= sel_src1;
            mul_src2 <= sel_src2;
            rsp_id   <= grant_idx;
            rr_ptr   <= rr_nxt;
            lat_cnt  <= LAT_LOAD;
          end
        end
        ST_ISSUE: begin
          if (lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
        end
        ST_COMBINE: rsp_data <= mul_p1 + ((mul_p2 + mul_p3) << 16);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_cell_arbiter.sv
// Bench for mult_cell_arbiter: two instances (latency 1 and 3) share the input
// stimulus, each with its own behavioural multiply cell; sel picks which one is checked.
module tb_mult_cell_arbiter;

  localparam int LA = 1;
  localparam int LB = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [63:0] req_src1, req_src2;
  logic        rsp_ready;
  logic        sel;

  logic [1:0]  a_req_ready, b_req_ready;
  logic        a_rsp_valid, b_rsp_valid;
  logic [0:0]  a_rsp_id, b_rsp_id;
  logic [31:0] a_rsp_data, b_rsp_data;
  logic [31:0] a_mul_src1, a_mul_src2, b_mul_src1, b_mul_src2;
  logic        a_mul_en, b_mul_en;
  logic [31:0] a_mul_p1, a_mul_p2, a_mul_p3, b_mul_p1, b_mul_p2, b_mul_p3;
  logic        a_busy, b_busy;

  logic [1:0]  o_req_ready;
  logic        o_rsp_valid, o_mul_en, o_busy;
  logic [0:0]  o_rsp_id;
  logic [31:0] o_rsp_data, o_mul_src1, o_mul_src2;

  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  mult_cell_arbiter #(.NUM_REQ(2), .ID_W(1), .MUL_LATENCY(LA)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .rsp_valid(a_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(a_rsp_id), .rsp_data(a_rsp_data),
    .mul_src1(a_mul_src1), .mul_src2(a_mul_src2), .mul_en(a_mul_en),
    .mul_p1(a_mul_p1), .mul_p2(a_mul_p2), .mul_p3(a_mul_p3), .busy(a_busy));

  mult_cell_arbiter #(.NUM_REQ(2), .ID_W(1), .MUL_LATENCY(LB)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .rsp_valid(b_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data),
    .mul_src1(b_mul_src1), .mul_src2(b_mul_src2), .mul_en(b_mul_en),
    .mul_p1(b_mul_p1), .mul_p2(b_mul_p2), .mul_p3(b_mul_p3), .busy(b_busy));

  assign o_req_ready = sel ? b_req_ready : a_req_ready;
  assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign o_rsp_id    = sel ? b_rsp_id    : a_rsp_id;
  assign o_rsp_data  = sel ? b_rsp_data  : a_rsp_data;
  assign o_mul_src1  = sel ? b_mul_src1  : a_mul_src1;
  assign o_mul_src2  = sel ? b_mul_src2  : a_mul_src2;
  assign o_mul_en    = sel ? b_mul_en    : a_mul_en;
  assign o_busy      = sel ? b_busy      : a_busy;

  function automatic logic [31:0] pp(input logic [15:0] x, input logic [15:0] y);
    return {16'h0, x} * {16'h0, y};
  endfunction

  // Behavioural multiply cells: a 3-deep enabled shift pipeline, tapped at the latency.
  logic [31:0] a_pp1 [3], a_pp2 [3], a_pp3 [3];
  logic [31:0] b_pp1 [3], b_pp2 [3], b_pp3 [3];

  always @(posedge clk) begin
    if (a_mul_en) begin
      a_pp1[0] <= pp(a_mul_src1[15:0],  a_mul_src2[15:0]);
      a_pp2[0] <= pp(a_mul_src1[15:0],  a_mul_src2[31:16]);
      a_pp3[0] <= pp(a_mul_src1[31:16], a_mul_src2[15:0]);
      for (int i = 1; i < 3; i++) begin
        a_pp1[i] <= a_pp1[i-1];
        a_pp2[i] <= a_pp2[i-1];
        a_pp3[i] <= a_pp3[i-1];
      end
    end
  end

  always @(posedge clk) begin
    if (b_mul_en) begin
      b_pp1[0] <= pp(b_mul_src1[15:0],  b_mul_src2[15:0]);
      b_pp2[0] <= pp(b_mul_src1[15:0],  b_mul_src2[31:16]);
      b_pp3[0] <= pp(b_mul_src1[31:16], b_mul_src2[15:0]);
      for (int i = 1; i < 3; i++) begin
        b_pp1[i] <= b_pp1[i-1];
        b_pp2[i] <= b_pp2[i-1];
        b_pp3[i] <= b_pp3[i-1];
      end
    end
  end

  assign a_mul_p1 = a_pp1[LA-1];
  assign a_mul_p2 = a_pp2[LA-1];
  assign a_mul_p3 = a_pp3[LA-1];
  assign b_mul_p1 = b_pp1[LB-1];
  assign b_mul_p2 = b_pp2[LB-1];
  assign b_mul_p3 = b_pp3[LB-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  // Single transaction on one requester with rsp_ready high; starts at posedge+2 in IDLE.
  task automatic run_txn(input string tag, input int id, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] exp, input int lat);
    int cyc;
    int en_cnt;
    logic [1:0] mask;
    mask = 2'b01 << id;
    req_valid = mask;
    req_src1  = '0;
    req_src2  = '0;
    req_src1[32*id +: 32] = s1;
    req_src2[32*id +: 32] = s2;
    rsp_ready = 1'b1;
    #1 chk($sformatf("%s_grant", tag), 32'(o_req_ready), 32'(mask));
    @(posedge clk);
    #2 req_valid = '0;
    cyc = 1;
    en_cnt = 0;
    chk($sformatf("%s_msrc1", tag), o_mul_src1, s1);
    chk($sformatf("%s_msrc2", tag), o_mul_src2, s2);
    while (!o_rsp_valid && cyc < 20) begin
      if (o_mul_en) en_cnt++;
      @(posedge clk);
      #2;
      cyc++;
    end
    chk($sformatf("%s_latency", tag), 32'(cyc), 32'(lat + 2));
    chk($sformatf("%s_mul_en_cycles", tag), 32'(en_cnt), 32'(lat));
    chk($sformatf("%s_data", tag), o_rsp_data, exp);
    chk($sformatf("%s_id", tag), 32'(o_rsp_id), 32'(id));
    @(posedge clk);
    #2;
    chk($sformatf("%s_rsp_drop", tag), 32'(o_rsp_valid), 32'd0);
    chk($sformatf("%s_idle", tag), 32'(o_busy), 32'd0);
  endtask

  typedef struct {
    logic [31:0] s1;
    logic [31:0] s2;
    int          id;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int grants [$];
    int ids [$];
    int seen;
    int cyc;
    int model_rr;
    logic [31:0] rs1 [2];
    logic [31:0] rs2 [2];

    vecs[0] = '{32'h0001_0002, 32'h0003_0004, 0, 32'h000A_0008};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_0001};
    vecs[2] = '{32'h8000_0000, 32'h0000_0002, 1, 32'h0000_0000};
    vecs[3] = '{32'h0000_FFFF, 32'h0000_FFFF, 1, 32'hFFFE_0001};
    vecs[4] = '{32'h1234_5678, 32'h0000_0010, 0, 32'h2345_6780};
    vecs[5] = '{32'h0001_0000, 32'h0001_0000, 1, 32'h0000_0000};
    vecs[6] = '{32'h0000_0007, 32'h0000_0006, 1, 32'h0000_002A};

    sel       = 1'b0;
    reset     = 1'b1;
    req_valid = '0;
    req_src1  = '0;
    req_src2  = '0;
    rsp_ready = 1'b0;

    // Reset values
    do_reset();
    chk("rst_req_ready", 32'(o_req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(o_rsp_id),    32'd0);
    chk("rst_rsp_data",  o_rsp_data,       32'd0);
    chk("rst_mul_src1",  o_mul_src1,       32'd0);
    chk("rst_mul_src2",  o_mul_src2,       32'd0);
    chk("rst_mul_en",    32'(o_mul_en),    32'd0);
    chk("rst_busy",      32'(o_busy),      32'd0);

    // Vector table, latency-1 instance
    for (int v = 0; v < 7; v++)
      run_txn($sformatf("vec%0d", v), vecs[v].id, vecs[v].s1, vecs[v].s2, vecs[v].exp, LA);

    // Reset while in ISSUE aborts the transaction (rsp_data is nonzero going in)
    req_valid = 2'b01;
    req_src1  = {32'h0, 32'h0000_0003};
    req_src2  = {32'h0, 32'h0000_0005};
    rsp_ready = 1'b1;
    @(posedge clk);
    #2 req_valid = '0;
    chk("abort_in_issue", 32'(o_mul_en), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("abort_req_ready", 32'(o_req_ready), 32'd0);
    chk("abort_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("abort_rsp_id",    32'(o_rsp_id),    32'd0);
    chk("abort_rsp_data",  o_rsp_data,       32'd0);
    chk("abort_mul_src1",  o_mul_src1,       32'd0);
    chk("abort_mul_src2",  o_mul_src2,       32'd0);
    chk("abort_mul_en",    32'(o_mul_en),    32'd0);
    chk("abort_busy",      32'(o_busy),      32'd0);
    reset = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #2;
      if (o_rsp_valid) seen = 1;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);

    // Contention: both requesters held valid after reset
    do_reset();
    req_src1  = {32'd5, 32'd3};
    req_src2  = {32'd7, 32'd11};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int c = 0; c < 60 && ids.size() < 4; c++) begin
      #1;
      if (o_req_ready != 2'b00) grants.push_back(o_req_ready[1] ? 1 : 0);
      if (o_rsp_valid) begin
        ids.push_back(int'(o_rsp_id));
        chk("cont_data", o_rsp_data, (o_rsp_id == 1'b0) ? 32'd33 : 32'd35);
      end
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    chk("cont_rsp_count", 32'(ids.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cont_grant%0d", k), (k < grants.size()) ? 32'(grants[k]) : 32'd99, 32'(k % 2));
      chk($sformatf("cont_id%0d", k),    (k < ids.size())    ? 32'(ids[k])    : 32'd99, 32'(k % 2));
    end

    // Backpressure in RESP with requester 1 waiting
    do_reset();
    req_valid = 2'b01;
    req_src1  = {32'h0000_0009, 32'h0001_0002};
    req_src2  = {32'h0000_0009, 32'h0003_0004};
    #1 chk("bp_grant", 32'(o_req_ready), 32'd1);
    @(posedge clk);
    #2 req_valid = 2'b10;
    rsp_ready = 1'b0;
    cyc = 1;
    while (!o_rsp_valid && cyc < 20) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    chk("bp_latency", 32'(cyc), 32'(LA + 2));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #2;
      chk("bp_rsp_valid", 32'(o_rsp_valid), 32'd1);
      chk("bp_data",      o_rsp_data,       32'h000A_0008);
      chk("bp_id",        32'(o_rsp_id),    32'd0);
      chk("bp_req_ready", 32'(o_req_ready), 32'd0);
      chk("bp_busy",      32'(o_busy),      32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("bp_accept",     32'(o_rsp_valid), 32'd0);
    chk("bp_next_grant", 32'(o_req_ready), 32'd2);
    req_valid = '0;
    @(posedge clk);
    #2;

    // Randomized traffic against a round-robin reference model
    do_reset();
    model_rr = 0;
    for (int t = 0; t < 40; t++) begin
      int g;
      logic [1:0] mask;
      logic [31:0] exp;
      int stall;
      mask   = 2'($urandom_range(0, 3));
      rs1[0] = $urandom;
      rs1[1] = $urandom;
      rs2[0] = $urandom;
      rs2[1] = $urandom;
      req_src1  = {rs1[1], rs1[0]};
      req_src2  = {rs2[1], rs2[0]};
      req_valid = mask;
      rsp_ready = 1'b0;
      #1;
      if (mask == 2'b00) begin
        chk("rnd_no_grant", 32'(o_req_ready), 32'd0);
        @(posedge clk);
        #2;
        continue;
      end
      g = -1;
      for (int k = 0; k < 2; k++)
        if (g < 0 && mask[(model_rr + k) % 2]) g = (model_rr + k) % 2;
      chk("rnd_grant", 32'(o_req_ready), 32'(1 << g));
      @(posedge clk);
      #2 req_valid = '0;
      model_rr = (g + 1) % 2;
      exp = rs1[g] * rs2[g];
      cyc = 1;
      while (!o_rsp_valid && cyc < 20) begin
        @(posedge clk);
        #2;
        cyc++;
      end
      chk("rnd_latency", 32'(cyc), 32'(LA + 2));
      stall = $urandom_range(0, 3);
      repeat (stall) begin
        @(posedge clk);
        #2;
      end
      chk("rnd_data", o_rsp_data, exp);
      chk("rnd_id",   32'(o_rsp_id), 32'(g));
      rsp_ready = 1'b1;
      @(posedge clk);
      #2;
      chk("rnd_accept", 32'(o_rsp_valid), 32'd0);
      rsp_ready = 1'b0;
    end

    // Latency-3 instance
    do_reset();
    sel = 1'b1;
    run_txn("lat3", 0, 32'h0001_0002, 32'h0003_0004, 32'h000A_0008, LB);
    run_txn("lat3_wrap", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, LB);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
